// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stage enable/flush sequencer with dmem wait and stall counting
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic [1:0]       ex_jump,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q;
  logic            load_use, jump, mem_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q != ERR && !pc_en)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    load_use = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    jump     = |ex_jump;
    mem_miss = mem_access && !dmem_ack;

    case (state_q)
      RUN: begin
        if (mem_miss) begin
          // freeze from the very cycle the miss is seen
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else if (jump) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
        if (dmem_ack)
          state_d = RUN;
        else if (wait_q == WAIT_LIMIT)
          state_d = ERR;
        else
          wait_d = wait_q + WW'(1);
      end
      ERR: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign dmem_req        = mem_access && ((state_q == RUN) || (state_q == MEM_WAIT)) && rst_n;
  assign mem_timeout_err = (state_q == ERR);
  assign state           = state_q;
  assign stall_cnt       = cnt_q;

endmodule
